// File: rtl/regfile_dump_reader.sv
// ----------------------------------------------------------------------------
// regfile_dump_reader
//
// Walks a programmable register range through the register file's third read
// port (C) and streams each (address, data) pair to a debug sink over a
// valid/ready handshake. Read ports A/B and the write port are untouched.
//
// State table:
//   state | meaning
//   ------+------------------------------------------------------------------
//   IDLE  | waiting for start; range inputs latched when start is accepted
//   FETCH | rd_addr = cur; rd_data, cur and (cur == end) captured at the edge
//   SEND  | out_valid high, word held stable until out_valid && out_ready
//   DONE  | one-cycle done pulse, then back to IDLE
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   start, abort        begin a dump (IDLE only) / cancel the dump in progress
//   first_addr          first register of the range (latched on start)
//   last_addr           last register of the range (latched on start)
//   rd_addr, rd_data    register-file read port C (data combinational)
//   out_valid/out_ready handshake with the debug sink
//   out_addr/out_data   current word: register number and captured contents
//   out_last            current word is the last of the range
//   busy                high in any state other than IDLE
//   done                one-cycle pulse after the final word's handshake
// ----------------------------------------------------------------------------
module regfile_dump_reader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [ADDR_W-1:0] out_addr_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_last_q;
    logic              load_word;
    logic              clear_last;
    logic              handshake;

    assign handshake = (state_q == ST_SEND) && out_ready;

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        end_d      = end_q;
        load_word  = 1'b0;
        clear_last = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // abort beats a simultaneous start
                if (start && !abort) begin
                    cur_d   = first_addr;
                    end_d   = last_addr;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    clear_last = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    load_word = 1'b1;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                // abort wins over a handshake in the same cycle; the sink
                // still keeps that word, but nothing follows it
                if (abort) begin
                    clear_last = 1'b1;
                    state_d    = ST_IDLE;
                end else if (handshake) begin
                    if (out_last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        // natural wrap 31 -> 0 gives the wrapped ranges
                        cur_d   = cur_q + ADDR_W'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                if (abort) begin
                    clear_last = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cur_q      <= '0;
            end_q      <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            end_q   <= end_d;
            if (load_word) begin
                out_addr_q <= cur_q;
                out_data_q <= rd_data;
                out_last_q <= (cur_q == end_q);
            end else if (clear_last) begin
                out_last_q <= 1'b0;
            end
        end
    end

    // Port C is only driven during FETCH so it reads as address 0 otherwise.
    assign rd_addr   = (state_q == ST_FETCH) ? cur_q : '0;
    assign out_valid = (state_q == ST_SEND);
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// ----------------------------------------------------------------------------
// tb_regfile_dump_reader
//
// Self-checking bench: a table of dump ranges with hand-computed expectations,
// plus directed sequences for abort, reset mid-dump and start/abort in IDLE.
// A small register-file model answers read port C combinationally.
// ----------------------------------------------------------------------------
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [4:0]  first_addr;
    logic [4:0]  last_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];

    int errors = 0;
    int checks = 0;

    logic [4:0]  w_addr [$];
    logic [31:0] w_data [$];
    logic        w_last [$];
    int          last_hs_edge;
    int          done_edge;
    int          done_cnt;
    int          stall_viol;
    bit          timed_out;

    typedef struct {
        logic [4:0]  first;
        logic [4:0]  last;
        int          duty;
        bit          hold_start;
        int          exp_words;
        logic [4:0]  exp_last_addr;
        logic [31:0] exp_first_data;
        int          exp_last_edge;   // -1: not checked (random stalls)
    } vec_t;

    vec_t vecs [4];

    regfile_dump_reader #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    assign rd_data = regs[rd_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts a dump and runs it to completion, recording every handshake.
    // Sample index e counts edges after the start edge.
    task automatic run_dump(input logic [4:0] f, input logic [4:0] l,
                            input int duty, input bit hold);
        logic        pv, phs, pl;
        logic [4:0]  pa;
        logic [31:0] pd;
        w_addr.delete();
        w_data.delete();
        w_last.delete();
        last_hs_edge = -1;
        done_edge    = -1;
        done_cnt     = 0;
        stall_viol   = 0;
        timed_out    = 1'b1;
        pv = 1'b0; phs = 1'b0; pl = 1'b0; pa = '0; pd = '0;
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        out_ready  = 1'b0;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        for (int e = 0; e < 2000; e++) begin
            if (pv && !phs) begin
                if (out_valid !== 1'b1 || out_addr !== pa || out_data !== pd || out_last !== pl)
                    stall_viol++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_edge = e;
                start     = 1'b0;
            end
            if (busy === 1'b0) begin
                timed_out = 1'b0;
                break;
            end
            out_ready = (int'($urandom_range(0, 99)) < duty);
            pv  = out_valid;
            phs = out_valid && out_ready;
            pa  = out_addr;
            pd  = out_data;
            pl  = out_last;
            if (out_valid && out_ready) begin
                w_addr.push_back(out_addr);
                w_data.push_back(out_data);
                w_last.push_back(out_last);
                last_hs_edge = e + 1;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        start     = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] ea;
        int         idle_bad;
        bit         hit;

        regs[0] = 32'h0;
        for (int i = 1; i < 32; i++) regs[i] = 32'h1000_0000 + i;

        vecs[0] = '{first: 5'd0,  last: 5'd31, duty: 100, hold_start: 1'b0, exp_words: 32,
                    exp_last_addr: 5'd31, exp_first_data: 32'h0000_0000, exp_last_edge: 64};
        vecs[1] = '{first: 5'd5,  last: 5'd7,  duty: 30,  hold_start: 1'b0, exp_words: 3,
                    exp_last_addr: 5'd7,  exp_first_data: 32'h1000_0005, exp_last_edge: -1};
        vecs[2] = '{first: 5'd30, last: 5'd1,  duty: 100, hold_start: 1'b0, exp_words: 4,
                    exp_last_addr: 5'd1,  exp_first_data: 32'h1000_001E, exp_last_edge: 8};
        vecs[3] = '{first: 5'd9,  last: 5'd9,  duty: 100, hold_start: 1'b1, exp_words: 1,
                    exp_last_addr: 5'd9,  exp_first_data: 32'h1000_0009, exp_last_edge: 2};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        first_addr = '0; last_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst rd_addr",   rd_addr,   0);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_addr",  out_addr,  0);
        chk("rst out_data",  out_data,  0);
        chk("rst out_last",  out_last,  0);
        chk("rst busy",      busy,      0);
        chk("rst done",      done,      0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // start and abort together in IDLE: abort wins
        first_addr = 5'd3; last_addr = 5'd4;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("idle abort busy",  busy,      0);
        chk("idle abort valid", out_valid, 0);
        @(posedge clk); #1;

        foreach (vecs[v]) begin
            run_dump(vecs[v].first, vecs[v].last, vecs[v].duty, vecs[v].hold_start);
            chk($sformatf("v%0d timeout", v), timed_out, 0);
            chk($sformatf("v%0d word count", v), w_addr.size(), vecs[v].exp_words);
            for (int i = 0; i < w_addr.size(); i++) begin
                ea = vecs[v].first + 5'(i);
                chk($sformatf("v%0d w%0d addr", v, i), w_addr[i], ea);
                chk($sformatf("v%0d w%0d data", v, i), w_data[i], regs[ea]);
                chk($sformatf("v%0d w%0d last", v, i), w_last[i], (i == vecs[v].exp_words - 1));
            end
            if (w_addr.size() > 0) begin
                chk($sformatf("v%0d first data", v), w_data[0], vecs[v].exp_first_data);
                chk($sformatf("v%0d final addr", v), w_addr[w_addr.size()-1], vecs[v].exp_last_addr);
            end
            chk($sformatf("v%0d done pulses", v), done_cnt, 1);
            chk($sformatf("v%0d done timing", v), done_edge, last_hs_edge);
            chk($sformatf("v%0d stall stability", v), stall_viol, 0);
            if (vecs[v].exp_last_edge >= 0)
                chk($sformatf("v%0d last handshake edge", v), last_hs_edge, vecs[v].exp_last_edge);
            idle_bad = 0;
            repeat (5) begin
                @(posedge clk); #1;
                if (busy !== 1'b0 || out_valid !== 1'b0) idle_bad++;
            end
            chk($sformatf("v%0d idle after dump", v), idle_bad, 0);
        end

        // abort during SEND of addr 12, with r20 written while cur = 10
        w_addr.delete();
        hit = 1'b0;
        first_addr = 5'd0; last_addr = 5'd31;
        start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int e = 0; e < 200; e++) begin
            if (out_valid && out_addr == 5'd10) regs[20] = 32'hDEAD_BEEF;
            if (out_valid) w_addr.push_back(out_addr);
            if (out_valid && out_addr == 5'd12) begin
                abort = 1'b1;
                hit   = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("abort reached addr 12", hit, 1);
        @(posedge clk); #1;
        abort = 1'b0;
        out_ready = 1'b0;
        chk("abort busy",      busy,      0);
        chk("abort out_valid", out_valid, 0);
        chk("abort out_last",  out_last,  0);
        chk("abort done",      done,      0);
        idle_bad = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) idle_bad++;
        end
        chk("abort quiet after", idle_bad, 0);
        chk("abort word count", w_addr.size(), 13);
        if (w_addr.size() > 0) chk("abort final addr", w_addr[w_addr.size()-1], 12);
        regs[20] = 32'h1000_0014;

        // reset pulse during SEND of addr 3
        hit = 1'b0;
        first_addr = 5'd0; last_addr = 5'd31;
        start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int e = 0; e < 200; e++) begin
            if (out_valid && out_addr == 5'd3) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("reset reached addr 3", hit, 1);
        rst_n = 1'b0;
        #1;
        chk("mid rst rd_addr",   rd_addr,   0);
        chk("mid rst out_valid", out_valid, 0);
        chk("mid rst out_addr",  out_addr,  0);
        chk("mid rst out_data",  out_data,  0);
        chk("mid rst out_last",  out_last,  0);
        chk("mid rst busy",      busy,      0);
        chk("mid rst done",      done,      0);
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post rst idle", busy, 0);

        run_dump(5'd0, 5'd1, 100, 1'b0);
        chk("post rst timeout", timed_out, 0);
        chk("post rst words", w_addr.size(), 2);
        if (w_addr.size() == 2) begin
            chk("post rst w0 addr", w_addr[0], 0);
            chk("post rst w0 data", w_data[0], 32'h0000_0000);
            chk("post rst w1 addr", w_addr[1], 1);
            chk("post rst w1 data", w_data[1], 32'h1000_0001);
            chk("post rst w1 last", w_last[1], 1);
        end
        chk("post rst done", done_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Sequential reader for the CPU register file's third read port (address C / data C).
- On a start command, walks a programmable register range and streams each (address, data) pair to a downstream debug sink (UART formatter / VGA debug overlay) over a valid/ready handshake.
- Sits beside the register file and does not interfere with pipeline read ports A/B or the write port.

Parameters:
- ADDR_W, 5, register address width (32 registers).
- DATA_W, 32, register data width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a dump; sampled only in IDLE.
- abort  input  1  synchronous cancel of the dump in progress.
- first_addr  input  ADDR_W  first register of the range; latched on accepted start.
- last_addr  input  ADDR_W  last register of the range; latched on accepted start.
- rd_addr  output  ADDR_W  drives the register-file read-port-C address.
- rd_data  input  DATA_W  register-file read-port-C data; combinational, same cycle as rd_addr.
- out_valid  output  1  out_addr/out_data/out_last hold a word for the sink.
- out_ready  input  1  sink accepts the word this cycle.
- out_addr  output  ADDR_W  register number of the current word.
- out_data  output  DATA_W  captured register contents.
- out_last  output  1  current word is the final word of the range.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the final word's handshake.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; rd_addr=0; out_valid=0; out_addr=0; out_data=0; out_last=0; busy=0; done=0; latched range=0.
- States: IDLE, FETCH, SEND, DONE.
- IDLE:
  - start=1 latches first_addr into cur and last_addr into end, then goes to FETCH.
  - rd_addr=0.
- FETCH (1 cycle):
  - rd_addr=cur.
  - At the clock edge, out_data<=rd_data, out_addr<=cur, out_last<=(cur==end).
  - Goes to SEND.
- SEND:
  - out_valid=1; out_addr/out_data/out_last held stable until handshake (out_valid && out_ready).
  - On handshake with out_last=1: go to DONE.
  - On handshake otherwise: cur<=cur+1 (mod 2^ADDR_W, 31 wraps to 0), go to FETCH.
  - No handshake: stay in SEND, outputs unchanged.
- DONE (1 cycle):
  - done=1, out_valid=0.
  - Goes to IDLE; busy drops the cycle after DONE.
- Range arithmetic:
  - Word count = ((end - cur_start) mod 32) + 1.
  - first_addr > last_addr wraps through 31→0; e.g. 30..1 yields 30,31,0,1.
  - first_addr == last_addr yields exactly one word with out_last=1.
- Latency and throughput:
  - start accepted at edge N: first out_valid visible in cycle N+1 (after the FETCH edge). Worst-case first-word latency is 2 cycles.
  - Peak throughput is one word per 2 cycles with out_ready tied high.
- Register 0:
  - Read like any other address; the register file returns 0.
  - No special case in this block.
- Coherency:
  - No snapshot. Each register is sampled in its own FETCH cycle.
  - A write-back to a register that lands before its FETCH edge is visible in the dump; a write after that edge is not.
- start while busy: ignored; range inputs are not re-latched.
- abort=1 in FETCH/SEND/DONE:
  - Next state IDLE; out_valid=0 and out_last=0 next cycle; done not pulsed.
  - Priority over a simultaneous handshake; that word counts as delivered by the sink, but no further words follow.
- abort in IDLE: no effect; start and abort together in IDLE: abort wins, stay IDLE.
- rst_n asserted mid-dump: immediate return to reset values, no done; a new start is required after release.
- out_valid never deasserts without a handshake, except on abort or reset.

Test Plan:
- Preload r1..r31 with 0x1000_0000+i; start with first=0, last=31, out_ready=1 -> 32 words, addresses 0..31, data 0 then 0x1000_0001..0x1000_001F, out_last only on addr 31, done pulse 1 cycle after the last handshake, 64 cycles from start to the last handshake.
- Range 5..7, out_ready random 30% duty -> exactly 3 words (5,6,7); out_data stable throughout each stall; no duplicate or dropped words.
- Range first=30, last=1 -> order 30,31,0,1 with data 0x1000_001E, 0x1000_001F, 0, 0x1000_0001; out_last on addr 1.
- Range 9..9 -> single word addr 9, out_last=1, done pulse; a start pulse held during the dump produces no second dump.
- Range 0..31; write 0xDEAD_BEEF to r20 while cur=10; abort asserted during SEND of addr 12 -> r20 not reported; IDLE next cycle, out_valid=0, done never pulses.
- rst_n low for 1 cycle during SEND of addr 3 -> all outputs at reset values immediately; after release, a new start 0..1 yields words 0,1 normally.
